// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_driver
// Desc   : Time-multiplexed 4-digit seven-segment driver with a frame-synchronous
//          shadow load, hex decode and optional leading-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int                 c_cnt_w   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  // XOR masks that move the internal active-high view to pin polarity;
  // they double as the inactive pin level.
  localparam logic [3:0] c_an_inv  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] c_seg_inv = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       c_dp_inv  = ACTIVE_LOW ? 1'b1  : 1'b0;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [3:0]         dp_shadow_q, dp_shadow_d;
  logic [15:0]        disp_q, disp_d;
  logic [3:0]         dp_disp_q, dp_disp_d;
  logic               pending_q, pending_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               w_tick;
  logic               w_frame_end;
  logic [3:0]         w_nibble;
  logic               w_upper_zero;
  logic               w_blank;
  logic [6:0]         w_seg_raw;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  always_comb begin
    w_tick      = (cnt_q == c_cnt_max);
    w_frame_end = w_tick && (idx_q == 2'd3);
    cnt_d       = w_tick ? '0 : cnt_q + c_cnt_one;
    idx_d       = w_tick ? idx_q + 2'd1 : idx_q;

    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    disp_d      = disp_q;
    dp_disp_d   = dp_disp_q;
    pending_d   = pending_q;

    if (load) begin
      shadow_d    = value;
      dp_shadow_d = dp_in;
      pending_d   = 1'b1;
    end

    // A load landing on the frame-end tick bypasses the shadow entirely.
    if (w_frame_end && (pending_q || load)) begin
      disp_d    = load ? value : shadow_q;
      dp_disp_d = load ? dp_in : dp_shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    w_nibble = disp_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    w_upper_zero = (disp_q[15:12] == 4'h0);
      2'd2:    w_upper_zero = (disp_q[15:8] == 8'h00);
      2'd1:    w_upper_zero = (disp_q[15:4] == 12'h000);
      default: w_upper_zero = 1'b0;
    endcase
    w_blank   = blank_lz && w_upper_zero;
    w_seg_raw = w_blank ? 7'h00 : hex_to_seg(w_nibble);

    an_d  = (4'b0001 << idx_q) ^ c_an_inv;
    seg_d = w_seg_raw ^ c_seg_inv;
    dp_d  = dp_disp_q[idx_q] ^ c_dp_inv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      dp_shadow_q <= 4'h0;
      disp_q      <= 16'h0000;
      dp_disp_q   <= 4'h0;
      pending_q   <= 1'b0;
      an_q        <= c_an_inv;
      seg_q       <= c_seg_inv;
      dp_q        <= c_dp_inv;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      disp_q      <= disp_d;
      dp_disp_q   <= dp_disp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign pending = pending_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_scan_driver
// Desc   : Scoreboard bench for seg7_scan_driver (CLK_DIV=4, ACTIVE_LOW=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pending;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference model state: edges since reset, shown and latest-loaded data.
  int          m_cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_dpd = 4'h0;
  logic [15:0] m_latest = 16'h0;
  logic [3:0]  m_dpl = 4'h0;
  logic        m_pend = 1'b0;

  logic [6:0]  pat[16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  seg7_scan_driver #(.CLK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .pending(pending), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Model: the digit shown after edge k is slot (k/DIV)%4 of the value committed so far.
  always @(posedge clk) begin
    exp_t        e;
    int          d;
    logic [15:0] upper;
    if (reset) begin
      m_cyc = 0; m_disp = 16'h0; m_dpd = 4'h0; m_latest = 16'h0; m_dpl = 4'h0; m_pend = 1'b0;
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pending: 1'b0};
    end else begin
      d       = (m_cyc / DIV) % 4;
      upper   = m_disp >> (4 * d);
      e.an    = ~(4'b0001 << d);
      e.seg   = (blank_lz && d > 0 && upper == 16'h0) ? 7'h7F : ~pat[upper[3:0]];
      e.dp    = ~m_dpd[d];
      if (load) begin
        m_latest = value;
        m_dpl    = dp_in;
      end
      if ((m_cyc % FRAME) == FRAME - 1 && (m_pend || load)) begin
        m_disp = m_latest;
        m_dpd  = m_dpl;
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      e.pending = m_pend;
      m_cyc++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || pending !== e.pending) begin
        n_err++;
        $display("FAIL outputs t=%0t: got an=%b seg=%h dp=%b pending=%b, want an=%b seg=%h dp=%b pending=%b",
                 $time, an, seg, dp, pending, e.an, e.seg, e.dp, e.pending);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    run(1);
    load  = 1'b0;
  endtask

  // Advance until the next edge is at position p within the frame.
  task automatic wait_phase(input int p);
    int guard = 0;
    while ((m_cyc % FRAME) != p && guard < 4 * FRAME) begin
      run(1);
      guard++;
    end
  endtask

  initial begin
    logic [15:0] masks[5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    reset = 1'b1; value = 16'h0; dp_in = 4'h0; load = 1'b0; blank_lz = 1'b0;
    run(3);
    reset = 1'b0;
    run(40);

    wait_phase(5);  do_load(16'h12AF, 4'b0100); run(40);
    wait_phase(15); do_load(16'h0008, 4'b0000); run(20);
    wait_phase(2);  do_load(16'h1111, 4'b0000); run(3);
    do_load(16'h2222, 4'b0000); run(36);

    blank_lz = 1'b1;
    wait_phase(3); do_load(16'h0050, 4'b0000); run(36);
    wait_phase(3); do_load(16'h0000, 4'b0000); run(36);
    blank_lz = 1'b0;

    wait_phase(4); do_load(16'hBEEF, 4'hF); run(2);
    reset = 1'b1; run(2);
    reset = 1'b0; run(36);

    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      run(1);
    end
    reset = 1'b0; load = 1'b0;
    run(4);
    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
